// File: rtl/fan_timer_ctrl_pkg.sv
// Shared encodings for the fan front-panel controller: timer FSM states,
// timer-select codes, step multipliers and the fan speed codes used by the fan FSM.
package fan_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_EXPIRE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_OFF = 2'd0,
        SEL_1   = 2'd1,
        SEL_3   = 2'd2,
        SEL_5   = 2'd3
    } timer_sel_t;

    localparam int unsigned MULT_SEL_1 = 1;
    localparam int unsigned MULT_SEL_3 = 3;
    localparam int unsigned MULT_SEL_5 = 5;

    typedef enum logic [1:0] {
        FAN_OFF  = 2'd0,
        FAN_LOW  = 2'd1,
        FAN_MED  = 2'd2,
        FAN_HIGH = 2'd3
    } fan_speed_t;

    // Number of timer steps loaded for a given timer-select code.
    function automatic int unsigned sel_mult(input logic [1:0] sel);
        case (sel)
            SEL_1:   return MULT_SEL_1;
            SEL_3:   return MULT_SEL_3;
            SEL_5:   return MULT_SEL_5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fan_timer_ctrl_tick_gen.sv
// Free-running prescaler: counts 0..TICKS_PER_SEC-1 and flags the last count
// as a one-cycle tick. i_clear restarts the period from zero.
module fan_timer_ctrl_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/fan_timer_ctrl.sv
// Front-panel controller: turns button levels into one-cycle fan commands and
// runs the auto-off timer that issues an off command when it expires.
module fan_timer_ctrl
    import fan_timer_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC  = 100_000_000,
    parameter int unsigned TIMER_STEP_SEC = 60,
    parameter int unsigned REMAIN_W       = 10
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_button_R,
    input  logic                i_button_L,
    input  logic                i_button_D,
    input  logic                i_button_U,
    input  logic [1:0]          i_fanState,
    output logic                o_button_R,
    output logic                o_button_L,
    output logic                o_button_D,
    output logic [1:0]          o_timerSel,
    output logic [REMAIN_W-1:0] o_remain_sec,
    output logic                o_timer_active
);
    function automatic logic [REMAIN_W-1:0] reload_value(input logic [1:0] sel);
        return REMAIN_W'(sel_mult(sel) * TIMER_STEP_SEC);
    endfunction

    logic [3:0]          w_raw;
    logic [3:0]          w_rise;
    logic                w_fan_off;
    logic                w_tick;
    logic                w_clear;
    logic                w_expire;
    logic [1:0]          w_next_sel;

    logic [3:0]          r_prev;
    state_t              r_state;
    logic [1:0]          r_sel;
    logic [REMAIN_W-1:0] r_remain;
    logic                r_active;
    logic                r_btn_R;
    logic                r_btn_L;
    logic                r_btn_D;

    assign w_raw      = {i_button_U, i_button_D, i_button_L, i_button_R};
    assign w_rise     = w_raw & ~r_prev;
    assign w_fan_off  = (i_fanState == FAN_OFF);
    assign w_next_sel = r_sel + 2'd1;

    // Any reload (start or advance to a longer setting) restarts the second count.
    assign w_clear = w_rise[3] && !w_fan_off &&
                     ((r_state == ST_IDLE) || (r_state == ST_RUN && r_sel != SEL_5));

    // Cancel and U presses take precedence over the tick, so neither can expire.
    assign w_expire = (r_state == ST_RUN) && !w_fan_off && !w_rise[3] &&
                      w_tick && (r_remain == REMAIN_W'(1));

    fan_timer_ctrl_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev   <= '1;
            r_state  <= ST_IDLE;
            r_sel    <= SEL_OFF;
            r_remain <= '0;
            r_active <= 1'b0;
            r_btn_R  <= 1'b0;
            r_btn_L  <= 1'b0;
            r_btn_D  <= 1'b0;
        end else begin
            r_prev  <= w_raw;
            r_btn_R <= 1'b0;
            r_btn_L <= 1'b0;
            r_btn_D <= 1'b0;

            if (w_expire) begin
                r_btn_D <= 1'b1;
            end else if (r_state != ST_EXPIRE) begin
                if (w_rise[2])      r_btn_D <= 1'b1;
                else if (w_rise[0]) r_btn_R <= 1'b1;
                else if (w_rise[1]) r_btn_L <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rise[3] && !w_fan_off) begin
                        r_state  <= ST_RUN;
                        r_sel    <= SEL_1;
                        r_remain <= reload_value(SEL_1);
                        r_active <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_fan_off || (w_rise[3] && r_sel == SEL_5)) begin
                        r_state  <= ST_IDLE;
                        r_sel    <= SEL_OFF;
                        r_remain <= '0;
                        r_active <= 1'b0;
                    end else if (w_rise[3]) begin
                        r_sel    <= w_next_sel;
                        r_remain <= reload_value(w_next_sel);
                    end else if (w_tick && r_remain != '0) begin
                        r_remain <= r_remain - REMAIN_W'(1);
                        if (r_remain == REMAIN_W'(1)) begin
                            r_state  <= ST_EXPIRE;
                            r_active <= 1'b0;
                        end
                    end
                end
                ST_EXPIRE: begin
                    r_state <= ST_IDLE;
                    r_sel   <= SEL_OFF;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_sel    <= SEL_OFF;
                    r_remain <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_button_R     = r_btn_R;
    assign o_button_L     = r_btn_L;
    assign o_button_D     = r_btn_D;
    assign o_timerSel     = r_sel;
    assign o_remain_sec   = r_remain;
    assign o_timer_active = r_active;

endmodule

// File: tb/tb_fan_timer_ctrl.sv
// Scoreboard bench for fan_timer_ctrl: stimulus queues expected command pulses,
// a negedge monitor pops and compares them; timer status is checked directly.
module tb_fan_timer_ctrl;
    localparam int TPS  = 4;
    localparam int STEP = 2;
    localparam int RW   = 10;

    localparam logic [2:0] P_R = 3'b001;
    localparam logic [2:0] P_L = 3'b010;
    localparam logic [2:0] P_D = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          b_r = 1'b0;
    logic          b_l = 1'b0;
    logic          b_d = 1'b0;
    logic          b_u = 1'b0;
    logic [1:0]    fan = 2'd0;
    logic          o_r;
    logic          o_l;
    logic          o_d;
    logic [1:0]    o_sel;
    logic [RW-1:0] o_rem;
    logic          o_act;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    fan_timer_ctrl #(
        .TICKS_PER_SEC (TPS),
        .TIMER_STEP_SEC(STEP),
        .REMAIN_W      (RW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_button_R    (b_r),
        .i_button_L    (b_l),
        .i_button_D    (b_d),
        .i_button_U    (b_u),
        .i_fanState    (fan),
        .o_button_R    (o_r),
        .o_button_L    (o_l),
        .o_button_D    (o_d),
        .o_timerSel    (o_sel),
        .o_remain_sec  (o_rem),
        .o_timer_active(o_act)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every observed pulse must match the queue head in cycle and code.
    always @(negedge clk) begin
        logic [2:0] seen;
        seen = {o_d, o_l, o_r};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missing_pulse: expected code %b at cycle %0d, got no pulse", q[0].code, q[0].cyc);
            void'(q.pop_front());
        end
        if (seen != 3'b000) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: got code %b at cycle %0d, required none", seen, cyc);
            end else if (q[0].cyc != cyc || q[0].code != seen) begin
                mismatched++;
                $display("FAIL pulse: got code %b at cycle %0d, required code %b at cycle %0d",
                         seen, cyc, q[0].code, q[0].cyc);
                if (q[0].cyc == cyc) void'(q.pop_front());
            end else begin
                $display("pulse ok: code %b at cycle %0d", seen, cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [2:0] code);
        q.push_back('{cyc + 1, code});
    endtask

    task automatic check_st(input string name, input int sel, input int rem, input bit act);
        compared++;
        if (int'(o_sel) != sel || int'(o_rem) != rem || o_act != act) begin
            mismatched++;
            $display("FAIL %s: got sel=%0d remain=%0d active=%0b, required sel=%0d remain=%0d active=%0b",
                     name, o_sel, o_rem, o_act, sel, rem, act);
        end else begin
            $display("status %s: sel=%0d remain=%0d active=%0b", name, o_sel, o_rem, o_act);
        end
    endtask

    task automatic press_u();
        b_u = 1'b1;
        step(1);
        b_u = 1'b0;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check_st("reset", 0, 0, 1'b0);
        rst = 1'b0;
        step(2);

        // One pulse per press, however long the hold.
        b_r = 1'b1; expect_pulse(P_R); step(10); b_r = 1'b0; step(2);
        b_r = 1'b1; expect_pulse(P_R); step(10); b_r = 1'b0; step(2);

        // Full countdown at sel=1 ending in an expiry off command.
        fan = 2'd1; step(1);
        b_u = 1'b1; step(1); b_u = 1'b0;
        check_st("s2_load", 1, 2, 1'b1);
        step(3); check_st("s2_before_tick", 1, 2, 1'b1);
        step(1); check_st("s2_first_tick", 1, 1, 1'b1);
        step(3); check_st("s2_before_expire", 1, 1, 1'b1);
        q.push_back('{cyc + 1, P_D});
        step(1); check_st("s2_expire", 1, 0, 1'b0);
        step(1); check_st("s2_idle", 0, 0, 1'b0);
        step(2);

        // U with the fan off is ignored.
        fan = 2'd0; step(1);
        b_u = 1'b1; step(1); b_u = 1'b0;
        check_st("u_fan_off", 0, 0, 1'b0);
        step(2);

        // Cycle the setting through 1, 3, 5 steps and back to off.
        fan = 2'd2; step(1);
        b_u = 1'b1; step(1); b_u = 1'b0; check_st("s3_sel1", 1, 2, 1'b1);
        step(1);
        b_u = 1'b1; step(1); b_u = 1'b0; check_st("s3_sel2", 2, 6, 1'b1);
        step(1);
        b_u = 1'b1; step(1); b_u = 1'b0; check_st("s3_sel3", 3, 10, 1'b1);
        step(1);
        b_u = 1'b1; step(1); b_u = 1'b0; check_st("s3_off", 0, 0, 1'b0);
        step(2);

        // Fan turned off by the user cancels the timer without an off command.
        press_u();
        b_u = 1'b1; step(1); b_u = 1'b0;
        check_st("s4_run", 2, 6, 1'b1);
        fan = 2'd0; step(1);
        check_st("s4_cancel", 0, 0, 1'b0);
        step(3);
        fan = 2'd2; step(1);

        // Arbitration between simultaneous user rises.
        b_r = 1'b1; b_l = 1'b1; expect_pulse(P_R); step(1); b_r = 1'b0; b_l = 1'b0; step(2);
        b_d = 1'b1; b_r = 1'b1; expect_pulse(P_D); step(1); b_d = 1'b0; b_r = 1'b0; step(2);
        b_l = 1'b1; expect_pulse(P_L); step(1); b_l = 1'b0; step(2);

        // R rising on the expiry edge and during the expire cycle is dropped.
        for (int off = 7; off <= 8; off++) begin
            fan = 2'd1; step(1);
            b_u = 1'b1; step(1); b_u = 1'b0;
            q.push_back('{cyc + 8, P_D});
            step(off);
            b_r = 1'b1; step(2); b_r = 1'b0;
            check_st("s5_expire_idle", 0, 0, 1'b0);
            step(2);
        end

        // Reset mid-countdown, with every button held through reset.
        fan = 2'd2; step(1);
        press_u();
        b_u = 1'b1; step(1); b_u = 1'b0;
        check_st("s6_load", 2, 6, 1'b1);
        step(12);
        check_st("s6_remain3", 2, 3, 1'b1);
        rst = 1'b1; b_r = 1'b1; b_l = 1'b1; b_d = 1'b1; b_u = 1'b1;
        step(1);
        check_st("s6_reset", 0, 0, 1'b0);
        step(1);
        rst = 1'b0;
        step(3);
        check_st("s6_held", 0, 0, 1'b0);
        b_r = 1'b0; b_l = 1'b0; b_d = 1'b0; b_u = 1'b0;
        step(12);
        check_st("s6_aborted", 0, 0, 1'b0);
        b_r = 1'b1; expect_pulse(P_R); step(1); b_r = 1'b0;
        step(4);

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: got %0d outstanding pulses, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fan_timer_ctrl.md
# fan_timer_ctrl

Controller that sits between the debounced front-panel buttons and the fan speed FSM. It converts held button levels into single-cycle command pulses, so one press moves the fan exactly one step. It also runs an auto-off timer that injects a "fan off" command on expiry. It owns the timer setting and the remaining-time count, which drive the display.

## Interface

**Parameters**
- `TICKS_PER_SEC`, default 100_000_000: i_clk cycles per one-second tick.
- `TIMER_STEP_SEC`, default 60: seconds per timer step.
- `REMAIN_W`, default 10: width of the remaining-seconds counter. Must hold 5*TIMER_STEP_SEC.

**Ports**
- `i_clk`, input, 1: system clock.
- `i_reset`, input, 1: reset. Synchronous, active-high.
- `i_button_R`, input, 1: speed up. Level; debounced and synchronised upstream.
- `i_button_L`, input, 1: speed down. Level.
- `i_button_D`, input, 1: fan off. Level.
- `i_button_U`, input, 1: cycle timer setting. Level.
- `i_fanState`, input, 2: current fan speed, 0..3, from the fan FSM.
- `o_button_R`, output, 1: one-cycle speed-up command to the fan FSM.
- `o_button_L`, output, 1: one-cycle speed-down command.
- `o_button_D`, output, 1: one-cycle off command, from the user or from timer expiry.
- `o_timerSel`, output, 2: 0 = off, 1 = 1 step, 2 = 3 steps, 3 = 5 steps.
- `o_remain_sec`, output, REMAIN_W: seconds remaining. 0 when the timer is off.
- `o_timer_active`, output, 1: high while the timer is counting.

## Operation

**Edge detection**
- Each raw input has a prev register, reset to 1. A button held through reset therefore produces no pulse.
- A rise is `raw & ~prev`.

**User command pulses**
- At most one command pulse is issued per cycle.
- Priority: expiry-D > user-D > R > L. Lower-priority rises in the same cycle are dropped, not queued.

**FSM states**
- `ST_IDLE`
  - Timer off: o_timerSel=0, o_remain_sec=0, o_timer_active=0.
  - A U rise while i_fanState != 0 → `ST_RUN` with sel=1, remain=TIMER_STEP_SEC, prescaler cleared.
  - A U rise while i_fanState == 0 is ignored.
- `ST_RUN`
  - A U rise advances sel 1→2→3→0.
    - To 2: remain reloads to 3*STEP and the prescaler clears.
    - To 3: remain reloads to 5*STEP and the prescaler clears.
    - To 0: → `ST_IDLE`.
  - On each tick, remain decrements.
  - A tick with remain==1 → `ST_EXPIRE`, with remain=0.
  - i_fanState==0 sampled while in `ST_RUN` (user turned the fan off) → `ST_IDLE`, sel=0. This is a cancel, not an expiry, so no pulse is issued.
- `ST_EXPIRE`
  - Lasts one cycle. o_button_D is asserted, then → `ST_IDLE`, sel=0.
  - User R/L/D rises in this cycle are dropped.

**Simultaneous events**
- A U rise and a tick in the same cycle: the reload wins and the tick is discarded.
- A tick and a U-to-0 rise in the same cycle: go to `ST_IDLE`, no expiry.

**Widths**
- remain is unsigned and never wraps. Decrement happens only when remain > 0.

## Timing

- **Reset values.** All o_button_* = 0, o_timerSel = 0, o_remain_sec = 0, o_timer_active = 0, state = `ST_IDLE`, prescaler = 0. Reset mid-countdown aborts it with no D pulse.
- **Button latency.** Raw rise first sampled at edge N → command pulse high for exactly the cycle after edge N, i.e. registered with 1-cycle latency.
- **Tick.** The first tick after a reload occurs TICKS_PER_SEC cycles after the reload edge. Ticks recur every TICKS_PER_SEC cycles.
- **Expiry.** The tick edge takes remain 1→0 and moves the state to `ST_EXPIRE`. o_button_D is high the following cycle. o_timer_active drops at the same edge that enters `ST_EXPIRE`.
- **Outputs.** o_timerSel and o_remain_sec are registered and update on the edge that changes state.

## Structure

- **Shared package:** state encodings `ST_IDLE`/`ST_RUN`/`ST_EXPIRE`, timer-select codes, the step-multiplier constants (1, 3, 5), and the fan speed codes shared with the fan FSM.
- **Sub-module `tick_gen`:** prescaler counting 0..TICKS_PER_SEC-1 with a synchronous clear input and a one-cycle tick output. It is reused by other timer blocks.
- **Top:** edge detection, command arbitration and the timer FSM stay in the top module.

## Test plan

All scenarios use TICKS_PER_SEC=4, TIMER_STEP_SEC=2.

1. Hold R for 10 cycles from reset → exactly one o_button_R pulse, 1 cycle after the rise. Release and repeat → a second pulse.
2. i_fanState=1, one U press → o_timerSel=1, o_remain_sec=2. After 4 cycles remain=1. After 8 cycles remain=0, then one o_button_D pulse, then sel=0, active=0.
3. i_fanState=2, press U three times 2 cycles apart → remain reloads 2, 6, 10. Fourth press → `ST_IDLE`, remain=0, no D pulse.
4. Running, remain=6, drive i_fanState=0 → next cycle `ST_IDLE`, sel=0, no o_button_D.
5. R and L rise in the same cycle → only o_button_R pulses. Expiry cycle coincident with an R rise → only o_button_D pulses.
6. i_reset asserted mid-countdown with remain=3 → all outputs 0 the next cycle, no D pulse. Buttons held through reset release → no pulses.
